stage_write_multi: RTL and testbench

- Parametrised multi-lane writeback/retire stage. Successor to the single-lane write stage.
- Sits after memory1 and registers a group of up to LANES instructions per cycle. Lane 0 is the oldest.
- Drives the register-file write ports to decode, per lane.
- Reports the oldest exception and the oldest flush to the CSR unit, and maintains the retired-instruction counter.

---
 rtl/stage_write_multi.sv | 125 ++++++++++++
 tb/tb_stage_write_multi.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_write_multi.sv
// Multi-lane writeback/retire stage: registers a group of LANES instructions
// from memory1, drives per-lane register-file writes and reports the oldest event.
module stage_write_multi #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int CNT_W = 64,
    parameter int EC_W  = 4
) (
    input  logic                    clk_core,
    input  logic                    reset,
    input  logic [LANES-1:0]        mem1_valid,
    input  logic [LANES-1:0]        mem1_exc,
    input  logic [LANES*EC_W-1:0]   mem1_exc_cause,
    input  logic [LANES-1:0]        mem1_flush,
    input  logic [LANES*30-1:0]     mem1_pc,
    input  logic [LANES*5-1:0]      mem1_wb_reg,
    input  logic [LANES*XLEN-1:0]   mem1_dout,
    output logic                    wb_stall,
    input  logic                    csr_kill,
    output logic [LANES-1:0]        wb_we,
    output logic [LANES*5-1:0]      wb_reg,
    output logic [LANES*XLEN-1:0]   wb_data,
    output logic                    wb_valid,
    output logic                    wb_exc,
    output logic [EC_W-1:0]         wb_exc_cause,
    output logic [29:0]             wb_exc_pc,
    output logic                    wb_flush,
    output logic [29:0]             wb_pc,
    output logic [CNT_W-1:0]        instret
);

    logic [LANES-1:0]              valid_q;
    logic [LANES-1:0]              exc_q;
    logic [LANES-1:0]              flush_q;
    logic [LANES-1:0][EC_W-1:0]    cause_q;
    logic [LANES-1:0][29:0]        pc_q;
    logic [LANES-1:0][4:0]         reg_q;
    logic [LANES-1:0][XLEN-1:0]    data_q;
    logic                          ev_q;
    logic [CNT_W-1:0]              instret_q;
    logic [CNT_W-1:0]              instret_d;

    logic [LANES-1:0]              live;
    logic [LANES-1:0]              retire;
    logic [LANES-1:0]              weLanes;
    logic [CNT_W-1:0]              retireCnt;
    logic                          blocked;
    logic                          excHit;
    logic [EC_W-1:0]               excCause;
    logic [29:0]                   excPc;
    logic [29:0]                   evPc;
    logic                          eventNow;
    logic                          stallNow;

    // Lanes younger than the first event are squashed; the youngest writer of a register wins.
    always_comb begin
        blocked   = 1'b0;
        live      = '0;
        for (int i = 0; i < LANES; i++) begin
            live[i] = valid_q[i] & ~blocked;
            if (valid_q[i] & (exc_q[i] | flush_q[i])) blocked = 1'b1;
        end
        retire    = live & ~exc_q;
        weLanes   = '0;
        retireCnt = '0;
        for (int i = 0; i < LANES; i++) begin
            weLanes[i] = retire[i] & (reg_q[i] != 5'd0);
            for (int j = i + 1; j < LANES; j++) begin
                if (retire[j] && (reg_q[j] == reg_q[i])) weLanes[i] = 1'b0;
            end
            retireCnt = retireCnt + CNT_W'(retire[i]);
        end
        excHit   = 1'b0;
        excCause = '0;
        excPc    = '0;
        evPc     = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (live[i] & exc_q[i]) begin
                excHit   = 1'b1;
                excCause = cause_q[i];
                excPc    = pc_q[i];
            end
            if (live[i] & (exc_q[i] | flush_q[i])) evPc = pc_q[i];
        end
        eventNow  = excHit | (|(live & flush_q));
        stallNow  = eventNow & ~ev_q;
        instret_d = (!stallNow && !csr_kill) ? instret_q + retireCnt : instret_q;
    end

    // Kill beats stall; a stalled group holds and is counted only on the edge it leaves.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            valid_q   <= '0;
            ev_q      <= 1'b0;
            instret_q <= '0;
        end else begin
            ev_q      <= eventNow;
            instret_q <= instret_d;
            if (csr_kill) begin
                valid_q <= '0;
            end else if (!stallNow) begin
                valid_q <= mem1_valid;
                exc_q   <= mem1_exc;
                flush_q <= mem1_flush;
                cause_q <= mem1_exc_cause;
                pc_q    <= mem1_pc;
                reg_q   <= mem1_wb_reg;
                data_q  <= mem1_dout;
            end
        end
    end

    assign wb_stall     = stallNow;
    assign wb_we        = weLanes;
    assign wb_reg       = reg_q;
    assign wb_data      = data_q;
    assign wb_valid     = |live;
    assign wb_exc       = excHit;
    assign wb_exc_cause = excCause;
    assign wb_exc_pc    = excPc;
    assign wb_flush     = |(live & flush_q);
    assign wb_pc        = evPc;
    assign instret      = instret_q;

endmodule

// File: tb/tb_stage_write_multi.sv
// Directed and random checks of stage_write_multi against a lane-level
// behavioural model of the retire group.
module tb_stage_write_multi;

    localparam int L = 2;
    localparam int X = 32;
    localparam int C = 6;
    localparam int E = 4;
    localparam logic [E-1:0] IILLEGAL = 4'd2;

    logic                 clk_core = 1'b0;
    logic                 reset;
    logic [L-1:0]         mem1_valid, mem1_exc, mem1_flush;
    logic [L*E-1:0]       mem1_exc_cause;
    logic [L*30-1:0]      mem1_pc;
    logic [L*5-1:0]       mem1_wb_reg;
    logic [L*X-1:0]       mem1_dout;
    logic                 csr_kill;
    logic                 wb_stall, wb_valid, wb_exc, wb_flush;
    logic [L-1:0]         wb_we;
    logic [L*5-1:0]       wb_reg;
    logic [L*X-1:0]       wb_data;
    logic [E-1:0]         wb_exc_cause;
    logic [29:0]          wb_exc_pc, wb_pc;
    logic [C-1:0]         instret;

    int checks = 0;
    int failures = 0;

    // Model state: one record per lane plus event flag and counter
    bit             mV[L], mE[L], mF[L];
    logic [E-1:0]   mC[L];
    logic [29:0]    mPc[L];
    logic [4:0]     mR[L];
    logic [X-1:0]   mD[L];
    bit             mEv;
    logic [C-1:0]   mInstret;

    bit             expValid, expExc, expFlush, expStall;
    logic [L-1:0]   expWe;
    logic [E-1:0]   expCause;
    logic [29:0]    expExcPc, expPc;
    int             expRetCnt;

    stage_write_multi #(.LANES(L), .XLEN(X), .CNT_W(C), .EC_W(E)) dut (
        .clk_core(clk_core), .reset(reset),
        .mem1_valid(mem1_valid), .mem1_exc(mem1_exc), .mem1_exc_cause(mem1_exc_cause),
        .mem1_flush(mem1_flush), .mem1_pc(mem1_pc), .mem1_wb_reg(mem1_wb_reg),
        .mem1_dout(mem1_dout), .wb_stall(wb_stall), .csr_kill(csr_kill),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .wb_valid(wb_valid),
        .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause), .wb_exc_pc(wb_exc_pc),
        .wb_flush(wb_flush), .wb_pc(wb_pc), .instret(instret)
    );

    always #5 clk_core = ~clk_core;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic setLane(input int i, input bit v, input bit e, input logic [E-1:0] c,
                           input bit f, input logic [29:0] pc, input logic [4:0] r,
                           input logic [X-1:0] d);
        mem1_valid[i]           = v;
        mem1_exc[i]             = e;
        mem1_exc_cause[i*E +: E] = c;
        mem1_flush[i]           = f;
        mem1_pc[i*30 +: 30]     = pc;
        mem1_wb_reg[i*5 +: 5]   = r;
        mem1_dout[i*X +: X]     = d;
    endtask

    task automatic clearInputs();
        for (int i = 0; i < L; i++) setLane(i, 0, 0, '0, 0, '0, '0, '0);
    endtask

    task automatic randomLane(input int i);
        setLane(i, $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
                E'($urandom_range(0, 15)), $urandom_range(0, 6) == 0,
                30'($urandom), 5'($urandom_range(0, 7)), $urandom);
    endtask

    // Derive the group's visible outputs from the first event lane and a claimed-register set
    task automatic modelComb();
        int  firstEv;
        bit  ret[L];
        bit  claimed[32];
        firstEv = L;
        for (int i = 0; i < L; i++)
            if (firstEv == L && mV[i] && (mE[i] || mF[i])) firstEv = i;
        expValid  = 0;
        expRetCnt = 0;
        for (int i = 0; i < L; i++) begin
            bit lv;
            lv       = mV[i] && (i <= firstEv);
            expValid = expValid | lv;
            ret[i]   = lv && !mE[i];
            if (ret[i]) expRetCnt++;
        end
        for (int r = 0; r < 32; r++) claimed[r] = 0;
        expWe = '0;
        for (int i = L - 1; i >= 0; i--) begin
            if (ret[i] && mR[i] != 0 && !claimed[mR[i]]) begin
                expWe[i]       = 1'b1;
                claimed[mR[i]] = 1;
            end
        end
        expExc   = 0; expFlush = 0; expCause = '0; expExcPc = '0; expPc = '0;
        if (firstEv < L) begin
            expExc   = mE[firstEv];
            expFlush = mF[firstEv];
            expCause = mC[firstEv];
            expExcPc = mPc[firstEv];
            expPc    = mPc[firstEv];
        end
        expStall = (expExc || expFlush) && !mEv;
    endtask

    task automatic checkOutput();
        check("wb_valid", 64'(wb_valid), 64'(expValid));
        check("wb_we",    64'(wb_we),    64'(expWe));
        check("wb_exc",   64'(wb_exc),   64'(expExc));
        check("wb_flush", 64'(wb_flush), 64'(expFlush));
        check("wb_pc",    64'(wb_pc),    64'(expPc));
        check("wb_stall", 64'(wb_stall), 64'(expStall));
        check("instret",  64'(instret),  64'(mInstret));
        if (expExc) begin
            check("wb_exc_cause", 64'(wb_exc_cause), 64'(expCause));
            check("wb_exc_pc",    64'(wb_exc_pc),    64'(expExcPc));
        end
        for (int i = 0; i < L; i++) begin
            if (expWe[i]) begin
                check("wb_reg",  64'(wb_reg[i*5 +: 5]),  64'(mR[i]));
                check("wb_data", 64'(wb_data[i*X +: X]), 64'(mD[i]));
            end
        end
    endtask

    // Advance the model across one edge with the current inputs, then compare after the edge
    task automatic applyStimulus();
        modelComb();
        if (reset) begin
            for (int i = 0; i < L; i++) mV[i] = 0;
            mEv      = 0;
            mInstret = '0;
        end else begin
            if (!expStall && !csr_kill) mInstret = mInstret + C'(expRetCnt);
            if (csr_kill) begin
                for (int i = 0; i < L; i++) mV[i] = 0;
            end else if (!expStall) begin
                for (int i = 0; i < L; i++) begin
                    mV[i]  = mem1_valid[i];
                    mE[i]  = mem1_exc[i];
                    mF[i]  = mem1_flush[i];
                    mC[i]  = mem1_exc_cause[i*E +: E];
                    mPc[i] = mem1_pc[i*30 +: 30];
                    mR[i]  = mem1_wb_reg[i*5 +: 5];
                    mD[i]  = mem1_dout[i*X +: X];
                end
            end
            mEv = expExc || expFlush;
        end
        @(posedge clk_core);
        #1;
        modelComb();
        checkOutput();
    endtask

    initial begin
        for (int i = 0; i < L; i++) begin
            mV[i] = 0; mE[i] = 0; mF[i] = 0; mC[i] = '0; mPc[i] = '0; mR[i] = '0; mD[i] = '0;
        end
        mEv = 0; mInstret = '0;
        reset = 1'b1; csr_kill = 1'b0;
        clearInputs();
        applyStimulus();
        applyStimulus();
        reset = 1'b0;

        // Two independent writers
        setLane(0, 1, 0, '0, 0, 30'h10, 5'd5, 32'h11);
        setLane(1, 1, 0, '0, 0, 30'h11, 5'd6, 32'h22);
        applyStimulus();
        // Same destination in both lanes: youngest wins
        setLane(0, 1, 0, '0, 0, 30'h12, 5'd7, 32'hAA);
        setLane(1, 1, 0, '0, 0, 30'h13, 5'd7, 32'hBB);
        applyStimulus();
        clearInputs();
        applyStimulus();

        // Oldest lane excepts
        setLane(0, 1, 1, IILLEGAL, 0, 30'h40, 5'd4, 32'h44);
        setLane(1, 1, 0, '0, 0, 30'h41, 5'd8, 32'h88);
        applyStimulus();
        clearInputs();
        applyStimulus();
        applyStimulus();

        // Oldest lane flushes, younger lane squashed
        setLane(0, 1, 0, '0, 1, 30'h80, 5'd3, 32'h33);
        setLane(1, 1, 0, '0, 0, 30'h81, 5'd9, 32'h99);
        applyStimulus();
        clearInputs();
        applyStimulus();
        applyStimulus();

        // Kill arriving during the held cycle
        setLane(0, 1, 0, '0, 1, 30'h90, 5'd2, 32'h2);
        applyStimulus();
        csr_kill = 1'b1;
        applyStimulus();
        csr_kill = 1'b0;
        clearInputs();
        applyStimulus();

        // Reset arriving during the held cycle
        setLane(0, 1, 1, IILLEGAL, 0, 30'hA0, 5'd1, 32'h1);
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        applyStimulus();

        // Back-to-back event groups: only the first stalls
        setLane(0, 1, 0, '0, 1, 30'hB0, 5'd10, 32'hB0);
        setLane(1, 1, 0, '0, 0, 30'hB1, 5'd11, 32'hB1);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        clearInputs();
        applyStimulus();

        // Steady double retirement drives the counter through its wrap
        for (int n = 0; n < 40; n++) begin
            setLane(0, 1, 0, '0, 0, 30'($urandom), 5'($urandom_range(1, 31)), $urandom);
            setLane(1, 1, 0, '0, 0, 30'($urandom), 5'($urandom_range(1, 31)), $urandom);
            applyStimulus();
        end

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < L; i++) randomLane(i);
            csr_kill = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 49) == 0);
            applyStimulus();
        end
        reset = 1'b0; csr_kill = 1'b0;
        clearInputs();
        applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
